// File: rtl/shot_exchange_ctl.sv
// rtl/shot_exchange_ctl.sv - two-board shot exchange sequencer (turns, shot/answer framing, win/lose)
// Optional build macro SHOT_RETRY_EN: resend the last shot on answer timeout, up to MAX_RETRY times.
module shot_exchange_ctl #(
`ifdef SHOT_RETRY_EN
  parameter int MAX_RETRY      = 3,
`endif
  parameter int TIMEOUT_CYCLES = 65_000_000,
  parameter int HIT_TOTAL      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fleet_ready,
  input  logic       first_player,
  input  logic       shot_valid,
  input  logic [7:0] shot_pos,
  output logic       shot_ready,
  output logic       bad_shot,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       opp_shot_valid,
  output logic [7:0] opp_shot_pos,
  input  logic       own_hit_valid,
  input  logic       own_hit,
  output logic       ans_valid,
  output logic       ans_hit,
  output logic       my_turn,
  output logic       win,
  output logic       lose,
  output logic       link_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0] HT = 5'(HIT_TOTAL);
  localparam logic [7:0] F_READY = 8'h01;
  localparam logic [7:0] F_MISS  = 8'h02;
  localparam logic [7:0] F_HIT   = 8'h03;
  localparam logic [7:0] F_LOST  = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_MY, S_SEND_SHOT, S_WAIT, S_PEER, S_LOOKUP, S_SEND_ANS, S_OVER
  } state_t;

  state_t          state_q, state_d, rx_state;
  logic            tx_valid_q, tx_valid_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            ready_sent_q, ready_sent_d;
  logic            peer_rdy_q, peer_rdy_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [4:0]      hits_taken_q, hits_taken_d;
  logic [4:0]      hits_given_q, hits_given_d;
  logic [7:0]      opp_pos_q, opp_pos_d;
  logic            ans_valid_q, ans_valid_d;
  logic            ans_hit_q, ans_hit_d;
  logic            bad_shot_q, bad_shot_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            link_err_q, link_err_d;
`ifdef SHOT_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] R_MAX = RW'(MAX_RETRY);
  logic [RW-1:0]   retry_cnt_q, retry_cnt_d;
`endif

  logic       tx_fire;
  logic       shot_ok;
  logic [6:0] shot_idx;
  logic [6:0] rx_idx;
  logic       rx_is_shot;
  logic       rx_is_answer;
  logic [3:0] rx_row;
  logic [3:0] rx_col;

  assign tx_fire      = tx_valid_q & tx_ready;
  assign shot_ok      = (shot_pos[7:4] <= 4'd9) && (shot_pos[3:0] <= 4'd9);
  assign shot_idx     = {3'b000, shot_pos[7:4]} * 7'd10 + {3'b000, shot_pos[3:0]};
  assign rx_idx       = rx_data[6:0];
  assign rx_is_shot   = rx_valid & rx_data[7] & (rx_idx <= 7'd99);
  assign rx_is_answer = rx_valid & ((rx_data == F_HIT) || (rx_data == F_MISS) || (rx_data == F_LOST));
  assign rx_row       = 4'(rx_idx / 7'd10);
  assign rx_col       = 4'(rx_idx % 7'd10);

  always_comb begin
    state_d      = state_q;
    rx_state     = state_q;
    tx_valid_d   = tx_valid_q & ~tx_ready;
    tx_data_d    = tx_data_q;
    ready_sent_d = ready_sent_q;
    peer_rdy_d   = peer_rdy_q;
    timer_d      = timer_q;
    hits_taken_d = hits_taken_q;
    hits_given_d = hits_given_q;
    opp_pos_d    = opp_pos_q;
    ans_valid_d  = 1'b0;
    ans_hit_d    = ans_hit_q;
    bad_shot_d   = 1'b0;
    win_d        = win_q;
    lose_d       = lose_q;
    link_err_d   = link_err_q;
`ifdef SHOT_RETRY_EN
    retry_cnt_d  = retry_cnt_q;
`endif

    if (rx_valid && (rx_data == F_READY) && (state_q != S_OVER))
      peer_rdy_d = 1'b1;

    case (state_q)
      S_IDLE: if (fleet_ready) state_d = S_SYNC;
      S_SYNC: begin
        if (!ready_sent_q) begin
          tx_valid_d   = 1'b1;
          tx_data_d    = F_READY;
          ready_sent_d = 1'b1;
        end else if (!tx_valid_q && peer_rdy_q) begin
          state_d = first_player ? S_MY : S_PEER;
        end
      end
      S_MY: begin
        if (shot_valid) begin
          if (shot_ok) begin
            tx_valid_d = 1'b1;
            tx_data_d  = {1'b1, shot_idx};
            state_d    = S_SEND_SHOT;
          end else begin
            bad_shot_d = 1'b1;
          end
        end
      end
      S_SEND_SHOT: begin
        if (tx_fire) begin
          state_d  = S_WAIT;
          rx_state = S_WAIT;
          timer_d  = '0;
        end
      end
      S_WAIT: begin
        if (timer_q == T_LAST) begin
`ifdef SHOT_RETRY_EN
          // tx_data_q still holds the last shot frame, so a resend only re-raises valid
          if (retry_cnt_q == R_MAX) begin
            link_err_d = 1'b1;
            state_d    = S_OVER;
          end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            tx_valid_d  = 1'b1;
            state_d     = S_SEND_SHOT;
          end
`else
          link_err_d = 1'b1;
          state_d    = S_OVER;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PEER: ;
      S_LOOKUP: begin
        if (own_hit_valid) begin
          if (own_hit && (hits_taken_q != HT))
            hits_taken_d = hits_taken_q + 5'd1;
          tx_valid_d = 1'b1;
          tx_data_d  = (hits_taken_d == HT) ? F_LOST : (own_hit ? F_HIT : F_MISS);
          state_d    = S_SEND_ANS;
        end
      end
      S_SEND_ANS: begin
        if (tx_fire) begin
          if (tx_data_q == F_LOST) begin
            lose_d  = 1'b1;
            state_d = S_OVER;
          end else if (tx_data_q == F_HIT) begin
            state_d  = S_PEER;
            rx_state = S_PEER;
          end else begin
            state_d = S_MY;
          end
        end
      end
      S_OVER: tx_valid_d = 1'b0;
      default: state_d = S_IDLE;
    endcase

    // rx is evaluated against the post-handshake state so a byte landing on the tx handshake cycle is kept
    if (rx_state == S_WAIT && rx_is_answer) begin
      timer_d    = '0;
      tx_valid_d = 1'b0;
      link_err_d = link_err_q;
`ifdef SHOT_RETRY_EN
      retry_cnt_d = '0;
`endif
      if (rx_data == F_HIT) begin
        ans_valid_d = 1'b1;
        ans_hit_d   = 1'b1;
        if (hits_given_q != HT) hits_given_d = hits_given_q + 5'd1;
        state_d     = S_MY;
      end else if (rx_data == F_MISS) begin
        ans_valid_d = 1'b1;
        ans_hit_d   = 1'b0;
        state_d     = S_PEER;
      end else begin
        win_d   = 1'b1;
        state_d = S_OVER;
      end
    end
    if (rx_state == S_PEER && rx_is_shot) begin
      opp_pos_d = {rx_row, rx_col};
      state_d   = S_LOOKUP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      ready_sent_q <= 1'b0;
      peer_rdy_q   <= 1'b0;
      timer_q      <= '0;
      hits_taken_q <= '0;
      hits_given_q <= '0;
      opp_pos_q    <= '0;
      ans_valid_q  <= 1'b0;
      ans_hit_q    <= 1'b0;
      bad_shot_q   <= 1'b0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
      link_err_q   <= 1'b0;
`ifdef SHOT_RETRY_EN
      retry_cnt_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      ready_sent_q <= ready_sent_d;
      peer_rdy_q   <= peer_rdy_d;
      timer_q      <= timer_d;
      hits_taken_q <= hits_taken_d;
      hits_given_q <= hits_given_d;
      opp_pos_q    <= opp_pos_d;
      ans_valid_q  <= ans_valid_d;
      ans_hit_q    <= ans_hit_d;
      bad_shot_q   <= bad_shot_d;
      win_q        <= win_d;
      lose_q       <= lose_d;
      link_err_q   <= link_err_d;
`ifdef SHOT_RETRY_EN
      retry_cnt_q  <= retry_cnt_d;
`endif
    end
  end

  assign shot_ready     = (state_q == S_MY);
  assign my_turn        = (state_q == S_MY) || (state_q == S_SEND_SHOT) || (state_q == S_WAIT);
  assign opp_shot_valid = (state_q == S_LOOKUP);
  assign opp_shot_pos   = opp_pos_q;
  assign tx_valid       = tx_valid_q;
  assign tx_data        = tx_data_q;
  assign ans_valid      = ans_valid_q;
  assign ans_hit        = ans_hit_q;
  assign bad_shot       = bad_shot_q;
  assign win            = win_q;
  assign lose           = lose_q;
  assign link_err       = link_err_q;

endmodule

// File: tb/tb_shot_exchange_ctl.sv
// tb/tb_shot_exchange_ctl.sv - directed/randomized bench for shot_exchange_ctl with a game-level peer model
module tb_shot_exchange_ctl;
  localparam int TO   = 40;
  localparam int HT   = 20;
  localparam int MAXR = 3;
  localparam logic [7:0] F_READY = 8'h01;
  localparam logic [7:0] F_MISS  = 8'h02;
  localparam logic [7:0] F_HIT   = 8'h03;
  localparam logic [7:0] F_LOST  = 8'h04;

  logic       clk = 1'b0;
  logic       rst;
  logic       fleet_ready, first_player, shot_valid;
  logic [7:0] shot_pos;
  logic       shot_ready, bad_shot, tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       opp_shot_valid;
  logic [7:0] opp_shot_pos;
  logic       own_hit_valid, own_hit, ans_valid, ans_hit, my_turn, win, lose, link_err;

  int n_checks = 0;
  int n_errors = 0;
  int m_hits_taken;
  bit m_my_turn;

  shot_exchange_ctl #(.TIMEOUT_CYCLES(TO), .HIT_TOTAL(HT)) dut (
    .clk(clk), .rst(rst), .fleet_ready(fleet_ready), .first_player(first_player),
    .shot_valid(shot_valid), .shot_pos(shot_pos), .shot_ready(shot_ready), .bad_shot(bad_shot),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .opp_shot_valid(opp_shot_valid), .opp_shot_pos(opp_shot_pos),
    .own_hit_valid(own_hit_valid), .own_hit(own_hit),
    .ans_valid(ans_valid), .ans_hit(ans_hit), .my_turn(my_turn),
    .win(win), .lose(lose), .link_err(link_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic get_tx(input string tag, input logic [7:0] exp, input int hold);
    int n = 0;
    while (!tx_valid && n < 200) begin
      tick();
      n++;
    end
    chk1({tag, "_txvalid"}, tx_valid, 1'b1);
    if (tx_valid) begin
      for (int i = 0; i < hold; i++) tick();
      if (hold > 0) chk1({tag, "_held"}, tx_valid, 1'b1);
      chk8(tag, tx_data, exp);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fleet_ready = 1'b0; first_player = 1'b0; shot_valid = 1'b0; shot_pos = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; own_hit_valid = 1'b0; own_hit = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    m_hits_taken = 0;
    m_my_turn = 1'b0;
  endtask

  task automatic sync(input bit fp, input bit early);
    first_player = fp;
    if (early) begin
      send_rx(F_READY);
      tick();
      chk1("idle_no_tx", tx_valid, 1'b0);
    end
    fleet_ready = 1'b1;
    get_tx("ready_frame", F_READY, $urandom_range(0, 2));
    if (!early) begin
      repeat (3) tick();
      chk1("sync_waits_peer", my_turn, 1'b0);
      send_rx(F_READY);
    end
    repeat (3) tick();
    chk1("sync_my_turn", my_turn, fp);
    chk1("sync_shot_ready", shot_ready, fp);
    m_my_turn = fp;
  endtask

  task automatic my_shot(input int r, input int c, input logic [7:0] code);
    chk1("shot_ready_before", shot_ready, 1'b1);
    shot_pos   = 8'(r * 16 + c);
    shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    get_tx("shot_frame", 8'(128 + r * 10 + c), $urandom_range(0, 2));
    chk1("wait_my_turn", my_turn, 1'b1);
    chk1("wait_no_ready", shot_ready, 1'b0);
    send_rx(code);
    if (code == F_HIT) m_my_turn = 1'b1;
    else m_my_turn = 1'b0;
    chk1("ans_valid", ans_valid, code != F_LOST);
    if (code != F_LOST) chk1("ans_hit", ans_hit, code == F_HIT);
    chk1("turn_after_ans", my_turn, m_my_turn);
    chk1("win_after_ans", win, code == F_LOST);
    tick();
    chk1("ans_pulse_end", ans_valid, 1'b0);
  endtask

  task automatic peer_shot(input int r, input int c, input bit hit);
    logic [7:0] exp;
    send_rx(8'(128 + r * 10 + c));
    chk1("lookup_valid", opp_shot_valid, 1'b1);
    chk8("opp_pos", opp_shot_pos, 8'(r * 16 + c));
    repeat ($urandom_range(0, 2)) tick();
    chk1("lookup_held", opp_shot_valid, 1'b1);
    own_hit_valid = 1'b1;
    own_hit       = hit;
    tick();
    own_hit_valid = 1'b0;
    own_hit       = 1'b0;
    chk1("lookup_done", opp_shot_valid, 1'b0);
    if (hit) m_hits_taken++;
    if (m_hits_taken == HT) exp = F_LOST;
    else if (hit) exp = F_HIT;
    else exp = F_MISS;
    get_tx("answer_frame", exp, $urandom_range(0, 2));
    m_my_turn = (exp == F_MISS);
    chk1("turn_after_peer", my_turn, m_my_turn);
    chk1("lose_flag", lose, exp == F_LOST);
  endtask

  initial begin
    int r, c, n;
    bit h;
    logic [7:0] frame;

    do_reset();
    rst = 1'b1;
    tick();
    chk1("rst_tx_valid", tx_valid, 1'b0);
    chk1("rst_shot_ready", shot_ready, 1'b0);
    chk1("rst_my_turn", my_turn, 1'b0);
    chk1("rst_win", win, 1'b0);
    chk1("rst_lose", lose, 1'b0);
    chk1("rst_link_err", link_err, 1'b0);
    chk1("rst_opp_valid", opp_shot_valid, 1'b0);
    chk1("rst_ans_valid", ans_valid, 1'b0);
    chk1("rst_bad_shot", bad_shot, 1'b0);
    rst = 1'b0;

    sync(1'b1, 1'b1);
    my_shot(3, 7, F_HIT);

    shot_pos = 8'h3A; shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    chk1("bad_shot_col", bad_shot, 1'b1);
    chk1("bad_no_tx", tx_valid, 1'b0);
    tick();
    chk1("bad_pulse_end", bad_shot, 1'b0);
    chk1("bad_stays_turn", shot_ready, 1'b1);
    shot_pos = 8'({$urandom_range(10, 15), 4'($urandom_range(0, 15))}); shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    chk1("bad_shot_row", bad_shot, 1'b1);
    tick();
    chk1("bad_row_no_tx", tx_valid, 1'b0);

    send_rx(8'h85);
    chk1("shot_in_my_turn_ignored", opp_shot_valid, 1'b0);
    chk1("still_my_turn", shot_ready, 1'b1);

    for (int it = 0; it < 10; it++) begin
      r = $urandom_range(0, 9);
      c = $urandom_range(0, 9);
      if (m_my_turn) my_shot(r, c, ($urandom_range(0, 1) == 1) ? F_HIT : F_MISS);
      else begin
        h = (m_hits_taken < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
        peer_shot(r, c, h);
      end
    end
    if (m_my_turn) my_shot($urandom_range(0, 9), $urandom_range(0, 9), F_MISS);

    send_rx(8'hE4);
    send_rx(8'h07);
    tick();
    chk1("bad_idx_ignored", opp_shot_valid, 1'b0);
    chk1("unknown_no_tx", tx_valid, 1'b0);
    peer_shot(9, 9, 1'b0);
    my_shot($urandom_range(0, 9), $urandom_range(0, 9), F_MISS);

    for (int k = 0; k < HT && m_hits_taken < HT; k++)
      peer_shot($urandom_range(0, 9), $urandom_range(0, 9), 1'b1);
    chk1("lose_set", lose, 1'b1);
    chk1("lose_no_turn", shot_ready, 1'b0);
    send_rx(8'h85);
    chk1("over_rx_ignored", opp_shot_valid, 1'b0);
    repeat (3) tick();
    chk1("over_tx_idle", tx_valid, 1'b0);
    chk1("lose_sticky", lose, 1'b1);

    do_reset();
    chk1("rst_clears_lose", lose, 1'b0);
    sync(1'b0, 1'b0);
    peer_shot($urandom_range(0, 9), $urandom_range(0, 9), 1'b0);
    shot_pos = 8'h12; shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    tick();
    chk1("pending_tx", tx_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("rst_drops_tx", tx_valid, 1'b0);
    chk1("rst_mid_turn", my_turn, 1'b0);

    do_reset();
    sync(1'b1, 1'b1);
    r = $urandom_range(0, 9);
    c = $urandom_range(0, 9);
    frame = 8'(128 + r * 10 + c);
    shot_pos = 8'(r * 16 + c); shot_valid = 1'b1;
    tick();
    shot_valid = 1'b0;
    get_tx("to_shot", frame, 0);
`ifdef SHOT_RETRY_EN
    for (int k = 0; k < MAXR; k++) begin
      get_tx("resend_frame", frame, 0);
      chk1("retry_no_link_err", link_err, 1'b0);
    end
`endif
    n = 0;
    while (!link_err && n < 200) begin
      chk1("to_no_tx", tx_valid, 1'b0);
      tick();
      n++;
    end
    chk1("link_err_set", link_err, 1'b1);
    chk1("timeout_latency", (n >= TO - 2) && (n <= TO + 4), 1'b1);
    chk1("link_err_no_turn", my_turn, 1'b0);

    do_reset();
    sync(1'b1, 1'b1);
    my_shot($urandom_range(0, 9), $urandom_range(0, 9), F_LOST);
    repeat (3) tick();
    chk1("win_sticky", win, 1'b1);
    chk1("win_no_ready", shot_ready, 1'b0);
    chk1("win_tx_idle", tx_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
